// File: rtl/qsys_irq_aggregator_if.sv
// Avalon-MM slave port bundle for the interrupt aggregator register file.
interface qsys_irq_aggregator_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/qsys_irq_aggregator.sv
// Interrupt aggregator: synchronises irq sources, latches level/edge pending bits,
// masks them into one registered CPU irq and exposes a priority-encoded ACTIVE register.
module qsys_irq_aggregator #(
  parameter int unsigned N_IRQ        = 8,
  parameter logic [15:0] EDGE_DEFAULT = 16'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IRQ-1:0]      irq_in,
  qsys_irq_aggregator_if.slave  avs,
  output logic                  irq
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_ENABLE  = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_ACTIVE  = 3'd4;
  localparam logic [2:0] A_FORCE   = 3'd5;

  logic [N_IRQ-1:0] r_s1;
  logic [N_IRQ-1:0] r_s2;
  logic [N_IRQ-1:0] r_h;
  logic [N_IRQ-1:0] r_pend_edge;
  logic [N_IRQ-1:0] r_enable;
  logic [N_IRQ-1:0] r_edge;
  logic             r_irq;
  logic [DW-1:0]    r_rdata;

  logic             w_wr;
  logic [N_IRQ-1:0] w_wdata;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_force;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_pending;
  logic [N_IRQ-1:0] w_act;
  logic             w_any;
  logic [IW-1:0]    w_idx;
  logic [DW-1:0]    w_active;
  logic [DW-1:0]    w_rdata;
  logic             w_unused;

  assign w_wr     = avs.chipselect & ~avs.write_n;
  assign w_wdata  = avs.writedata[N_IRQ-1:0];
  assign w_unused = &{1'b0, avs.writedata};
  assign w_clr    = (w_wr && (avs.address == A_PENDING)) ? w_wdata : '0;
  assign w_force  = (w_wr && (avs.address == A_FORCE))   ? w_wdata : '0;
  assign w_rise   = r_s2 & ~r_h;

  // Level sources expose the synchronised input directly; edge sources the latched bit.
  assign w_pending = (r_edge & r_pend_edge) | (~r_edge & r_s2);
  assign w_act     = w_pending & r_enable;
  assign w_any     = |w_act;

  // Lowest-numbered enabled pending source wins.
  always_comb begin
    w_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_idx = IW'(i);
      end
    end
  end

  assign w_active = {w_any, 11'b0, w_idx};

  always_comb begin
    w_rdata = '0;
    case (avs.address)
      A_STATUS:  w_rdata = DW'(r_s2);
      A_PENDING: w_rdata = DW'(w_pending);
      A_ENABLE:  w_rdata = DW'(r_enable);
      A_EDGE:    w_rdata = DW'(r_edge);
      A_ACTIVE:  w_rdata = w_active;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_h  <= '0;
    end else begin
      r_s1 <= irq_in;
      r_s2 <= r_s1;
      r_h  <= r_s2;
    end
  end

  // Set beats clear; bits in level mode are held at zero so a later switch to edge starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_edge <= '0;
    end else begin
      r_pend_edge <= r_edge & ((r_pend_edge & ~w_clr) | w_rise | w_force);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= '0;
      r_edge   <= EDGE_DEFAULT[N_IRQ-1:0];
    end else begin
      if (w_wr && (avs.address == A_ENABLE)) begin
        r_enable <= w_wdata;
      end
      if (w_wr && (avs.address == A_EDGE)) begin
        r_edge <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_irq   <= w_any;
      r_rdata <= w_rdata;
    end
  end

  assign irq          = r_irq;
  assign avs.readdata = r_rdata;

endmodule

// File: tb/tb_qsys_irq_aggregator.sv
// Scoreboard bench for qsys_irq_aggregator: a per-edge reference model queues expected
// readdata/irq, an independent monitor compares them on the falling edge.
module tb_qsys_irq_aggregator;
  localparam int unsigned N_IRQ        = 8;
  localparam logic [15:0] EDGE_DEFAULT = 16'h0F0F;
  localparam logic [15:0] MASK         = 16'h00FF;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic [N_IRQ-1:0] irq_in  = '0;
  logic             irq;

  qsys_irq_aggregator_if bus ();

  qsys_irq_aggregator #(.N_IRQ(N_IRQ), .EDGE_DEFAULT(EDGE_DEFAULT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .avs     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] rd;
    logic        irq;
    logic [2:0]  addr;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: the last three input samples, latched edge bits, and the two R/W masks.
  logic [15:0] m_seen [3];
  logic [15:0] m_pend_e;
  logic [15:0] m_en;
  logic [15:0] m_edge;

  function automatic logic [15:0] pending_view();
    return ((m_edge & m_pend_e) | (~m_edge & m_seen[1])) & MASK;
  endfunction

  function automatic logic [15:0] active_view();
    logic [15:0] a;
    a = pending_view() & m_en;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (a[i]) return 16'h8000 | 16'(i);
    end
    return 16'h0000;
  endfunction

  function automatic logic [15:0] reg_view(input logic [2:0] a);
    case (a)
      3'd0:    return m_seen[1] & MASK;
      3'd1:    return pending_view();
      3'd2:    return m_en;
      3'd3:    return m_edge;
      3'd4:    return active_view();
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model: at every edge, predict what the DUT shows after it, then advance.
  initial begin
    logic [15:0] wd, clr, frc, rise;
    logic        wr;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) m_seen[i] = '0;
        m_pend_e = '0;
        m_en     = '0;
        m_edge   = EDGE_DEFAULT & MASK;
        sb_q.delete();
      end else begin
        sb_q.push_back('{rd: reg_view(bus.address), irq: |(pending_view() & m_en), addr: bus.address});
        wr   = bus.chipselect && !bus.write_n;
        wd   = bus.writedata & MASK;
        clr  = (wr && bus.address == 3'd1) ? wd : 16'h0;
        frc  = (wr && bus.address == 3'd5) ? wd : 16'h0;
        rise = m_seen[1] & ~m_seen[2];
        m_pend_e = m_edge & ((m_pend_e & ~clr) | rise | frc);
        if (wr && bus.address == 3'd2) m_en = wd;
        if (wr && bus.address == 3'd3) m_edge = wd;
        m_seen[2] = m_seen[1];
        m_seen[1] = m_seen[0];
        m_seen[0] = 16'(irq_in);
      end
    end
  end

  // Monitor: pops one prediction per cycle and compares both outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.readdata !== e.rd) begin
          errors++;
          $display("FAIL sb_readdata addr=%0d t=%0t: got %h expected %h", e.addr, $time, bus.readdata, e.rd);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL sb_irq t=%0t: got %b expected %b", $time, irq, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [15:0] exp, input string name);
    bus.address = a;
    tick();
    checks++;
    if (bus.readdata !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, bus.readdata, exp);
    end
  endtask

  task automatic irq_chk(input logic exp, input string name);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, irq, exp);
    end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    #2 reset_n = 1'b0;
    #1;
    irq_chk(1'b0, "irq_in_reset");
    checks++;
    if (bus.readdata !== 16'h0) begin
      errors++;
      $display("FAIL readdata_in_reset: got %h expected 0000", bus.readdata);
    end
    tick(2);
    reset_n = 1'b1;
    tick();

    // Reset values and a masked all-source pulse
    rd_chk(3'd3, 16'h000F, "edge_mode_reset");
    rd_chk(3'd2, 16'h0000, "enable_reset");
    rd_chk(3'd1, 16'h0000, "pending_reset");
    irq_in = 8'hFF;
    tick();
    irq_in = '0;
    tick(4);
    rd_chk(3'd1, 16'h000F, "pending_edges_latched");
    irq_chk(1'b0, "irq_masked");

    // Edge source latency and W1C
    wr(3'd3, 16'h0001);
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h0001);
    tick(2);
    irq_chk(1'b0, "irq_idle_edge0");
    irq_in = 8'h01;
    tick();
    irq_in = '0;
    tick(4);
    rd_chk(3'd1, 16'h0001, "pending_edge0");
    irq_chk(1'b1, "irq_edge0_held");
    wr(3'd1, 16'h0001);
    tick(2);
    irq_chk(1'b0, "irq_edge0_cleared");

    // Level source ignores W1C and follows the input
    wr(3'd3, 16'h0000);
    wr(3'd2, 16'h0004);
    irq_in = 8'h04;
    tick(4);
    irq_chk(1'b1, "irq_level2");
    wr(3'd1, 16'h0004);
    tick(2);
    rd_chk(3'd1, 16'h0004, "level_w1c_ignored");
    irq_chk(1'b1, "irq_level2_after_w1c");
    irq_in = '0;
    tick(4);
    irq_chk(1'b0, "irq_level2_dropped");

    // Priority encoding of ACTIVE
    wr(3'd3, 16'h00FF);
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'h00A8);
    wr(3'd2, 16'h00F0);
    rd_chk(3'd4, 16'h8005, "active_bit5");
    wr(3'd1, 16'h0020);
    rd_chk(3'd4, 16'h8007, "active_bit7");
    wr(3'd1, 16'h0080);
    rd_chk(3'd4, 16'h0000, "active_none");

    // Rising edge coincident with W1C: set wins
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h00FF);
    irq_in = 8'h02;
    tick();
    irq_in = '0;
    tick();
    wr(3'd1, 16'h0002);
    rd_chk(3'd1, 16'h0002, "collision_set_wins");

    // FORCE only reaches edge sources; unmapped and write-only reads return 0
    wr(3'd3, 16'h000F);
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'h00FF);
    rd_chk(3'd1, 16'h000F, "force_edge_only");
    rd_chk(3'd6, 16'h0000, "unmapped_addr6");
    rd_chk(3'd5, 16'h0000, "force_reads_zero");
    wr(3'd2, 16'hFFFF);
    rd_chk(3'd2, 16'h00FF, "enable_upper_bits_zero");

    // Randomised traffic checked by the scoreboard every cycle
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N_IRQ'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        bus.address    = 3'($urandom_range(1, 5));
        bus.writedata  = 16'($urandom);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
      end else begin
        bus.address    = 3'($urandom_range(0, 7));
        bus.writedata  = 16'($urandom);
        bus.chipselect = 1'($urandom_range(0, 1));
        bus.write_n    = 1'b1;
      end
      tick();
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in         = '0;
    tick(4);

    // Asynchronous reset mid-operation
    wr(3'd3, 16'h00FF);
    wr(3'd2, 16'h00FF);
    wr(3'd5, 16'h00FF);
    tick(2);
    irq_chk(1'b1, "irq_before_reset");
    reset_n = 1'b0;
    #1;
    irq_chk(1'b0, "irq_async_reset");
    tick();
    reset_n = 1'b1;
    tick(3);
    rd_chk(3'd1, 16'h0000, "pending_lost_after_reset");
    rd_chk(3'd2, 16'h0000, "enable_after_reset");
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
